// File: rtl/saradc_pkg.sv
// Shared definitions for the SAR ADC controller: state encoding and default parameters.
// Latency: n/a (package only).
// Backpressure: n/a.
package saradc_pkg;

    localparam int SARADC_NBITS         = 8;
    localparam int SARADC_SAMPLE_CYCLES = 4;
    localparam int SARADC_SETTLE_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        HOLD,
        SETTLE,
        COMPARE,
        DECIDE,
        DONE
    } sar_state_t;

endpackage

// File: rtl/saradc_sw_drv.sv
// Complementary S/SB switch-pair driver: both rails come from one register stage.
// Latency: 1 cycle from s_next to s/sb.
// Backpressure: none; the vector is loaded every cycle.
module saradc_sw_drv #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_next,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] sb
);

    // S and SB are separate flops loaded together so SB never passes through logic after S.
    always_ff @(posedge clk) begin
        if (rst) begin
            s  <= '0;
            sb <= '1;
        end else begin
            s  <= s_next;
            sb <= ~s_next;
        end
    end

endmodule

// File: rtl/saradc_sar_ctrl.sv
// SAR ADC conversion sequencer: sample, hold, then per-bit settle/compare/decide, MSB first.
// Latency: start at cycle 0 -> result_valid at SAMPLE_CYCLES + 1 + NBITS*(SETTLE_CYCLES+2) + 1.
// Backpressure: none; start is only accepted in IDLE and is dropped otherwise, abort wins.
module saradc_sar_ctrl
    import saradc_pkg::*;
#(
    parameter int NBITS         = SARADC_NBITS,
    parameter int SAMPLE_CYCLES = SARADC_SAMPLE_CYCLES,
    parameter int SETTLE_CYCLES = SARADC_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             cmp_en,
    input  logic             cmp_out,
    output logic             sw_sample_s,
    output logic             sw_sample_sb,
    output logic [NBITS-1:0] dac_s,
    output logic [NBITS-1:0] dac_sb,
    output logic [NBITS-1:0] result,
    output logic             result_valid
);

    // One down-counter serves both the sample window and the per-bit settle window.
    localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(NBITS);

    localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(NBITS - 1);

    sar_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [NBITS-1:0] code, code_nxt;

    logic [NBITS-1:0] trial_bit;
    logic             sample_nxt;
    logic [NBITS-1:0] dac_nxt;

    // Next-state, counter, bit index and partial code.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        code_nxt  = code;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SAMPLE;
                    cnt_nxt   = SAMPLE_LOAD;
                    code_nxt  = '0;
                end
            end
            SAMPLE: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            HOLD: begin
                idx_nxt  = IDX_MSB;
                code_nxt = '0;
                if (SETTLE_CYCLES == 0) begin
                    state_nxt = COMPARE;
                end else begin
                    state_nxt = SETTLE;
                    cnt_nxt   = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = COMPARE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            COMPARE: begin
                state_nxt = DECIDE;
            end
            DECIDE: begin
                code_nxt[idx] = cmp_out;
                if (idx == '0) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx - 1'b1;
                    if (SETTLE_CYCLES == 0) begin
                        state_nxt = COMPARE;
                    end else begin
                        state_nxt = SETTLE;
                        cnt_nxt   = SETTLE_LOAD;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    // Switch targets are derived from the next state so the pads change on the same edge as the state.
    always_comb begin
        trial_bit  = NBITS'(1) << idx_nxt;
        sample_nxt = (state_nxt == SAMPLE);
        dac_nxt    = '0;
        if (state_nxt == SETTLE || state_nxt == COMPARE || state_nxt == DECIDE) begin
            dac_nxt = code_nxt | trial_bit;
        end
    end

    // State, sequencing registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            code         <= '0;
            busy         <= 1'b0;
            cmp_en       <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            idx          <= idx_nxt;
            code         <= code_nxt;
            busy         <= (state_nxt != IDLE);
            cmp_en       <= (state_nxt == COMPARE);
            result_valid <= (state_nxt == DONE);
            if (state_nxt == DONE) begin
                result <= code_nxt;
            end
        end
    end

    saradc_sw_drv #(
        .WIDTH (1)
    ) u_sample_drv (
        .clk    (clk),
        .rst    (rst),
        .s_next (sample_nxt),
        .s      (sw_sample_s),
        .sb     (sw_sample_sb)
    );

    saradc_sw_drv #(
        .WIDTH (NBITS)
    ) u_dac_drv (
        .clk    (clk),
        .rst    (rst),
        .s_next (dac_nxt),
        .s      (dac_s),
        .sb     (dac_sb)
    );

endmodule

// File: tb/tb_saradc_sar_ctrl.sv
// Self-checking bench for saradc_sar_ctrl against a timeline/binary-search reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_saradc_sar_ctrl;

    localparam int NB     = 8;
    localparam int SC     = 4;
    localparam int ST     = 2;
    localparam int BIT_T  = ST + 2;
    localparam int DONE_T = SC + 1 + NB * BIT_T + 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic          busy;
    logic          cmp_en;
    logic          cmp_out;
    logic          sw_sample_s;
    logic          sw_sample_sb;
    logic [NB-1:0] dac_s;
    logic [NB-1:0] dac_sb;
    logic [NB-1:0] result;
    logic          result_valid;

    logic [NB-1:0] vin_code;
    logic [NB-1:0] last_res;
    int            n_chk;
    int            n_pass;

    saradc_sar_ctrl #(
        .NBITS         (NB),
        .SAMPLE_CYCLES (SC),
        .SETTLE_CYCLES (ST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .cmp_en       (cmp_en),
        .cmp_out      (cmp_out),
        .sw_sample_s  (sw_sample_s),
        .sw_sample_sb (sw_sample_sb),
        .dac_s        (dac_s),
        .dac_sb       (dac_sb),
        .result       (result),
        .result_valid (result_valid)
    );

    // Ideal comparator: Vin >= Vdac.
    assign cmp_out = (vin_code >= dac_s);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Trial code expected on the DAC at cycle t of a conversion of v (0 outside the bit phases).
    function automatic logic [NB-1:0] exp_dac(input int t, input logic [NB-1:0] v);
        logic [NB-1:0] code;
        int            b;
        code = '0;
        if (t <= SC + 1 || t >= DONE_T) return '0;
        b = NB - 1 - (t - SC - 2) / BIT_T;
        for (int j = NB - 1; j > b; j--) begin
            if (v >= (code | (8'd1 << j))) code = code | (8'd1 << j);
        end
        return code | (8'd1 << b);
    endfunction

    function automatic bit exp_cmp(input int t);
        return (t > SC + 1) && (t < DONE_T) && (((t - SC - 2) % BIT_T) == ST);
    endfunction

    task automatic check_pairs();
        check("smp_cmpl", sw_sample_s ^ sw_sample_sb, 1);
        check("dac_cmpl", dac_s ^ dac_sb, 8'hFF);
        check("no_overlap", sw_sample_s & (|dac_s), 0);
    endtask

    task automatic check_cycle(input int t, input logic [NB-1:0] v);
        check_pairs();
        check("busy", busy, 1);
        check("smp", sw_sample_s, (t <= SC));
        check("dac", dac_s, exp_dac(t, v));
        check("cmp_en", cmp_en, exp_cmp(t));
        check("rv", result_valid, (t == DONE_T));
        if (t == DONE_T) check("result", result, v);
    endtask

    // cut_kind: 0 = run to completion, 1 = abort at cycle cut_t, 2 = rst at cycle cut_t.
    task automatic run_conv(input logic [NB-1:0] v, input int cut_t, input int cut_kind);
        int n_cmp;
        int n_busy;
        vin_code = v;
        n_cmp    = 0;
        n_busy   = 0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int t = 1; t <= DONE_T; t++) begin
            check_cycle(t, v);
            n_cmp  += int'(cmp_en);
            n_busy += int'(busy);
            if (t == cut_t) begin
                if (cut_kind == 1) abort = 1'b1;
                else rst = 1'b1;
                tick();
                abort = 1'b0;
                rst   = 1'b0;
                if (cut_kind == 2) last_res = '0;
                check_pairs();
                check("cut_busy", busy, 0);
                check("cut_smp", sw_sample_s, 0);
                check("cut_dac", dac_s, 0);
                check("cut_cmp_en", cmp_en, 0);
                check("cut_rv", result_valid, 0);
                check("cut_result", result, last_res);
                for (int k = 0; k < 3; k++) begin
                    tick();
                    check("cut_idle_rv", result_valid, 0);
                    check("cut_idle_busy", busy, 0);
                end
                return;
            end
            tick();
        end
        last_res = v;
        check("n_cmp_en", n_cmp, NB);
        check("n_busy", n_busy, DONE_T);
        check("post_busy", busy, 0);
        check("post_rv", result_valid, 0);
        check("post_result", result, v);
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        vin_code = '0;
        last_res = '0;

        // Reset values, sampled while reset is still asserted.
        repeat (3) tick();
        check("rst_smp_s", sw_sample_s, 0);
        check("rst_smp_sb", sw_sample_sb, 1);
        check("rst_dac_s", dac_s, 0);
        check("rst_dac_sb", dac_sb, 8'hFF);
        check("rst_cmp_en", cmp_en, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_rv", result_valid, 0);
        rst = 1'b0;
        tick();

        // Main function and code extremes.
        run_conv(8'hA5, 0, 0);
        run_conv(8'h00, 0, 0);
        run_conv(8'hFF, 0, 0);
        for (int i = 0; i < 6; i++) begin
            run_conv(NB'($urandom_range(0, 255)), 0, 0);
        end

        // Abort at the first COMPARE of bit 3; result keeps the prior code.
        run_conv(8'hA5, 0, 0);
        run_conv(8'h6B, SC + 2 + (NB - 1 - 3) * BIT_T + ST, 1);

        // Abort and start together in IDLE: nothing starts.
        vin_code = 8'h77;
        start    = 1'b1;
        abort    = 1'b1;
        tick();
        start    = 1'b0;
        abort    = 1'b0;
        check("abort_start_busy", busy, 0);
        check("abort_start_smp", sw_sample_s, 0);
        tick();
        check("abort_start_busy2", busy, 0);
        check("abort_start_result", result, last_res);

        // start held high: one conversion every DONE_T+1 cycles.
        vin_code = 8'h3C;
        start    = 1'b1;
        tick();
        for (int t = 1; t <= 3 * (DONE_T + 1) - 1; t++) begin
            check_pairs();
            check("held_rv", result_valid, ((t % (DONE_T + 1)) == DONE_T));
            if ((t % (DONE_T + 1)) == DONE_T) check("held_result", result, 8'h3C);
            if (t == 3 * (DONE_T + 1) - 1) start = 1'b0;
            tick();
        end
        last_res = 8'h3C;
        check("held_idle_busy", busy, 0);
        tick();
        check("held_stop_busy", busy, 0);

        // rst during SETTLE of bit 6 after a completed conversion, then restart.
        run_conv(8'hA5, 0, 0);
        run_conv(8'hC3, SC + 2 + BIT_T, 2);
        tick();
        run_conv(8'h5A, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/saradc_sar_ctrl.md
Name: saradc_sar_ctrl

Overview:
Synchronous successive-approximation controller for the SAR ADC.
- Sequences the sampling switch and the binary-weighted capacitive-DAC switch bank, all built from complementary S/SB pass-gate switch pairs.
- Strobes the comparator and accumulates the NBITS result MSB-first.
- Sits between the digital start/result interface and the analog switch/comparator macros.
- Every switch control is a registered, strictly complementary pair.

Parameters:
- NBITS, 8, conversion resolution, i.e. number of DAC switch pairs. Legal range 2..16.
- SAMPLE_CYCLES, 4, clock cycles the sampling switch stays closed. Must be >= 1.
- SETTLE_CYCLES, 2, DAC settling cycles per bit before the comparator strobe. Must be >= 0.

Ports:
- clk  input  1  Conversion clock. All logic on the rising edge.
- rst  input  1  Synchronous, active-high reset.
- start  input  1  Conversion request. Accepted only in IDLE.
- abort  input  1  Synchronous abort. Returns the block to IDLE.
- busy  output  1  High from the cycle after start is accepted through DONE.
- cmp_en  output  1  Comparator strobe, one cycle per bit.
- cmp_out  input  1  Comparator decision, sampled in DECIDE. 1 means Vin >= Vdac.
- sw_sample_s  output  1  Sampling switch S. 1 means closed.
- sw_sample_sb  output  1  Always the complement of sw_sample_s.
- dac_s  output  NBITS  DAC switch S per bit. 1 means bottom plate on VREFP.
- dac_sb  output  NBITS  Always the bitwise complement of dac_s.
- result  output  NBITS  Last completed conversion code.
- result_valid  output  1  One-cycle pulse when result updates.

Behaviour:
- Reset values:
  - sw_sample_s=0, sw_sample_sb=1
  - dac_s=0, dac_sb=all ones
  - cmp_en=0, busy=0, result=0, result_valid=0
  - state=IDLE
- All outputs are driven directly from flops; no combinational paths from inputs to outputs.
- S/SB pairs are updated in the same register stage and are complementary in every cycle, including during reset.
- States:
  - IDLE → SAMPLE when start=1 and abort=0.
  - SAMPLE: sw_sample_s=1, dac_s=0. Lasts SAMPLE_CYCLES cycles, then → HOLD.
  - HOLD: one cycle, all switches open (sw_sample_s=0, dac_s=0). Break-before-make between sampling and DAC drive. Load bit index i=NBITS-1, then → SETTLE (or COMPARE if SETTLE_CYCLES=0).
  - SETTLE: dac_s = code with trial bit i set. Lasts SETTLE_CYCLES cycles, then → COMPARE.
  - COMPARE: trial code held, cmp_en=1 for exactly one cycle, then → DECIDE.
  - DECIDE: trial code held. Bit i of code := cmp_out. If i=0 → DONE; else i := i-1 and → SETTLE (or COMPARE).
  - DONE: result := code, result_valid=1, dac_s := 0. Then → IDLE.
- Latency:
  - Start accepted at cycle 0; result_valid fires at cycle SAMPLE_CYCLES + 1 + NBITS*(SETTLE_CYCLES+2) + 1. This is cycle 38 for the defaults.
  - Back-to-back conversions with start held high have a period of 39 cycles, because each conversion passes through one IDLE cycle.
- busy is high in SAMPLE, HOLD, SETTLE, COMPARE, DECIDE and DONE.
- start is ignored when the state is not IDLE. There is no queueing.
- abort=1 in any state: next state is IDLE.
  - Switch outputs return to their reset values on the next edge.
  - cmp_en=0, result_valid is not asserted, and result keeps its previous value.
- abort and start both high in IDLE: abort wins and no conversion starts.
- rst mid-conversion behaves like abort, and additionally clears result to 0.
- cmp_out is ignored outside DECIDE.
- The settle counter and the bit index are sized with $clog2. The bit index never underflows: DECIDE with i=0 exits to DONE.

Decomposition:
- Shared package saradc_pkg holds:
  - The state enum: IDLE, SAMPLE, HOLD, SETTLE, COMPARE, DECIDE, DONE.
  - Default parameter constants: SARADC_NBITS, SARADC_SAMPLE_CYCLES, SARADC_SETTLE_CYCLES.
- One sub-module, saradc_sw_drv: a parameterised-width register that takes a next-S vector and drives S together with its complement SB from a single flop stage.
  - Synchronous reset to S=0.
  - Instantiated once for the sampling switch (width 1) and once for the DAC bank (width NBITS).

Test Plan:
- Comparator model cmp_out = (vin_code >= dac_s); vin_code=8'hA5, single start pulse:
  - result=8'hA5 with result_valid at cycle 38.
  - cmp_en high exactly 8 cycles.
  - busy high for cycles 1..38.
- Code extremes:
  - vin_code=8'h00 → result=8'h00.
  - vin_code=8'hFF → result=8'hFF.
  - Trial codes on dac_s are 80,40,20,...,01 for 00 and 80,C0,E0,...,FF for FF.
- Switch integrity, every cycle of a full conversion:
  - sw_sample_sb==~sw_sample_s and dac_sb==~dac_s.
  - sw_sample_s and any dac_s bit are never 1 in the same cycle.
  - HOLD cycle (cycle 5) shows all S=0.
- abort asserted at the first COMPARE of bit 3:
  - Next cycle: state IDLE, dac_s=0, busy=0, no result_valid, result unchanged from the prior conversion.
- start held high continuously with vin_code=8'h3C:
  - result_valid pulses at cycles 38, 77, 116, each with result=8'h3C.
- rst asserted during SETTLE of bit 6 after a completed 8'hA5 conversion:
  - Next cycle all outputs at reset values, result=0.
  - A start pulse one cycle after rst deasserts is accepted normally.
